// File: rtl/lsu.sv
// RV32I load/store unit: one request at a time, byte-lane strobes toward a memory with a
// registered one-cycle read port, load-data extraction and rejection of bad accesses.
module lsu #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_strobe,
    output logic [3:0]  mem_wr_strobe,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic [3:0]  wr_strobe_q, wr_strobe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        req_err;
    logic        illegal, misaligned, out_of_range;
    logic [3:0]  st_strobe;
    logic [31:0] st_wdata;
    logic [31:0] ld_shifted;
    logic [31:0] ld_data;

    assign req_ready     = (state_q == StIdle) && !rst;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_rd_strobe = rd_strobe_q;
    assign mem_wr_strobe = wr_strobe_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;

    always_comb begin
        illegal      = req_we ? !(req_funct3 inside {3'b000, 3'b001, 3'b010})
                              : !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = {2'b00, req_addr[31:2]} >= MEM_SIZE;
        req_err      = illegal || misaligned || out_of_range;
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                st_strobe = 4'b0001 << req_addr[1:0];
                st_wdata  = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_strobe = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata  = {2{req_wdata[15:0]}};
            end
            default: begin
                st_strobe = 4'b1111;
                st_wdata  = req_wdata;
            end
        endcase
    end

    // Formatting uses the captured width/offset, never the live request inputs.
    always_comb begin
        ld_shifted = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_data = {24'b0, ld_shifted[7:0]};
            3'b101:  ld_data = {16'b0, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_strobe_d = rd_strobe_q;
        wr_strobe_d = wr_strobe_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = StResp;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_we) begin
                            mem_wdata_d = st_wdata;
                            wr_strobe_d = st_strobe;
                        end else begin
                            rd_strobe_d = 1'b1;
                        end
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                rd_strobe_d = 1'b0;
                wr_strobe_d = 4'b0000;
                if (we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = ld_data;
                state_d     = StResp;
            end
            StResp: begin
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_strobe_q <= rd_strobe_d;
            wr_strobe_q <= wr_strobe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: byte-strobed memory model, response scoreboard, timing and reset checks.
module tb_lsu;

    localparam int unsigned MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rd_strobe;
    logic [3:0]  mem_wr_strobe;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] shadow [0:1023];
    logic [32:0] sb [$];
    logic [32:0] mon_e;
    int          checks = 0;
    int          errors = 0;
    int          rsp_cnt = 0;

    lsu #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rd_strobe (mem_rd_strobe),
        .mem_wr_strobe (mem_wr_strobe),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        automatic logic [31:0] w;
        w = mem[mem_addr[11:2]];
        for (int i = 0; i < 4; i++)
            if (mem_wr_strobe[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        if (|mem_wr_strobe) mem[mem_addr[11:2]] <= w;
        if (mem_rd_strobe) mem_rdata <= mem[mem_addr[11:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour, byte by byte; stores update the shadow image.
    function automatic logic [32:0] model(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [31:0] wd);
        logic [1:0]  o;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        logic        bad;
        o   = addr[1:0];
        bad = (addr >> 2) >= MEM_SIZE;
        if (we) bad = bad || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    bad = bad || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (f3[1:0] == 2'b01 && o[0]) bad = 1'b1;
        if (f3[1:0] == 2'b10 && o != 2'b00) bad = 1'b1;
        if (bad) return {1'b1, 32'h0};
        w = shadow[addr[11:2]];
        if (we) begin
            if (f3 == 3'd0) w[8*o +: 8] = wd[7:0];
            else if (f3 == 3'd1) begin
                if (o[1]) w[31:16] = wd[15:0];
                else      w[15:0]  = wd[15:0];
            end else w = wd;
            shadow[addr[11:2]] = w;
            return 33'h0;
        end
        b = 8'(w >> (8 * o));
        h = 16'(w >> (8 * o));
        case (f3)
            3'd0:    return {1'b0, {24{b[7]}}, b};
            3'd1:    return {1'b0, {16{h[15]}}, h};
            3'd4:    return {1'b0, 24'h0, b};
            3'd5:    return {1'b0, 16'h0, h};
            default: return {1'b0, w};
        endcase
    endfunction

    always @(negedge clk) begin
        if (rsp_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_rsp: got response with %0d pending, expected none", sb.size());
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e[32]});
                chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
                rsp_cnt++;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [32:0] exp, input int lat,
                         input logic [3:0] strb, input logic [31:0] wexp);
        int n;
        wait_ready();
        void'(model(we, f3, addr, wd));
        sb.push_back(exp);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (lat == 0) begin
            chk("err_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("err_strobes", {27'h0, mem_rd_strobe, mem_wr_strobe}, 32'h0);
        end else begin
            chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (we) begin
                chk("wr_strobe", {28'h0, mem_wr_strobe}, {28'h0, strb});
                chk("mem_wdata", mem_wdata, wexp);
            end else begin
                chk("rd_strobe", {27'h0, mem_rd_strobe, mem_wr_strobe}, 32'h10);
            end
        end
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(posedge clk);
            #1 n++;
            if (n == 1) chk("strobe_drop", {27'h0, mem_rd_strobe, mem_wr_strobe}, 32'h0);
        end
        chk("latency", n, lat);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {rsp_valid, rsp_err, mem_rd_strobe, mem_wr_strobe, req_ready}, 8'h0);
        chk({tag, "_rdata"}, rsp_rdata | mem_addr | mem_wdata, 32'h0);
    endtask

    initial begin
        int k, cnt0;
        logic [1:0]  kk, o;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b0;
        #1 chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        drive(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 33'h0, 1, 4'b1111, 32'hDEADBEEF);
        drive(1'b0, 3'd2, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 2, 4'b0, 32'h0);
        drive(1'b1, 3'd2, 32'h10, 32'h80F27F01, 33'h0, 1, 4'b1111, 32'h80F27F01);
        drive(1'b0, 3'd0, 32'h13, 32'h0, {1'b0, 32'hFFFFFF80}, 2, 4'b0, 32'h0);
        drive(1'b0, 3'd4, 32'h13, 32'h0, {1'b0, 32'h00000080}, 2, 4'b0, 32'h0);
        drive(1'b0, 3'd1, 32'h12, 32'h0, {1'b0, 32'hFFFF80F2}, 2, 4'b0, 32'h0);
        drive(1'b0, 3'd5, 32'h12, 32'h0, {1'b0, 32'h000080F2}, 2, 4'b0, 32'h0);
        drive(1'b0, 3'd0, 32'h11, 32'h0, {1'b0, 32'h0000007F}, 2, 4'b0, 32'h0);
        drive(1'b1, 3'd0, 32'h15, 32'hAB, 33'h0, 1, 4'b0010, 32'hABABABAB);
        drive(1'b1, 3'd1, 32'h16, 32'h1234, 33'h0, 1, 4'b1100, 32'h12341234);
        drive(1'b0, 3'd2, 32'h14, 32'h0, {1'b0, 32'h1234AB00}, 2, 4'b0, 32'h0);

        drive(1'b0, 3'd2, 32'h12, 32'h0, {1'b1, 32'h0}, 0, 4'b0, 32'h0);
        drive(1'b0, 3'd1, 32'h11, 32'h0, {1'b1, 32'h0}, 0, 4'b0, 32'h0);
        drive(1'b1, 3'd2, 32'h1001, 32'h55, {1'b1, 32'h0}, 0, 4'b0, 32'h0);
        drive(1'b0, 3'd3, 32'h20, 32'h0, {1'b1, 32'h0}, 0, 4'b0, 32'h0);
        drive(1'b1, 3'd4, 32'h20, 32'h66, {1'b1, 32'h0}, 0, 4'b0, 32'h0);
        drive(1'b0, 3'd2, 4 * MEM_SIZE, 32'h0, {1'b1, 32'h0}, 0, 4'b0, 32'h0);

        // Reset while a load is in ISSUE: nothing is pushed, so any response is flagged.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk_zero("rst_issue");
        @(negedge clk) rst = 1'b0;
        #1 chk("rst_issue_ready", {31'h0, req_ready}, 32'h1);

        // Reset while a load is in WAIT.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk_zero("rst_wait");
        @(negedge clk) rst = 1'b0;
        #1 chk("rst_wait_ready", {31'h0, req_ready}, 32'h1);
        repeat (5) @(negedge clk);

        // req_valid held for 20 cycles with alternating loads and stores.
        cnt0 = rsp_cnt;
        k = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (req_ready) begin
                kk = 2'(k);
                if (k % 2 == 0) begin
                    case ((k / 2) % 5)
                        0: f3 = 3'd0;
                        1: f3 = 3'd4;
                        2: f3 = 3'd1;
                        3: f3 = 3'd5;
                        default: f3 = 3'd2;
                    endcase
                end else begin
                    f3 = 3'((k / 2) % 3);
                end
                o = (f3[1:0] == 2'b00) ? kk : (f3[1:0] == 2'b01) ? {kk[1], 1'b0} : 2'b00;
                a = 32'h40 + 32'(4 * (k % 3)) + {30'h0, o};
                req_we     = k[0];
                req_funct3 = f3;
                req_addr   = a;
                req_wdata  = $urandom;
                sb.push_back(model(req_we, f3, a, req_wdata));
                k++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("hold_accepts", k, 6);
        chk("hold_rsp_count", rsp_cnt - cnt0, k);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
